// File: rtl/otter_icache.sv
// Direct-mapped read-only instruction cache, 4-word lines held in flops, refilled word by word.
// Optional hit/miss counters are enabled with the OTTER_ICACHE_STATS_EN macro.
module otter_icache #(
  parameter int unsigned LINES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] CPU_ADDR,
  input  logic        CPU_RD,
  input  logic        CPU_FLUSH,
  output logic [31:0] CPU_INSTR,
  output logic        CPU_VALID,
  output logic        CPU_STALL,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
`ifdef OTTER_ICACHE_STATS_EN
  ,
  output logic [31:0] STAT_HITS,
  output logic [31:0] STAT_MISSES
`endif
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 28 - IdxW;

  typedef enum logic [1:0] {StLookup, StRefill, StFilled} state_e;

  state_e            state_q, state_d;
  logic [31:2]       addr_q;
  logic              pend_q, pend_d;
  logic [1:0]        word_q, word_d;
  logic              flush_seen_q, flush_seen_d;
  logic [LINES-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];
  logic [31:0]       line_q [4];

  logic [IdxW-1:0]   idx;
  logic [1:0]        off;
  logic [TagW-1:0]   tag;
  logic              hit;
  logic              lookup_hit;
  logic              miss_start;
  logic              fill_done;
  logic              capture;

  // Byte-lane bits of the fetch address carry no information for a word cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^CPU_ADDR[1:0];

  assign idx     = addr_q[4 +: IdxW];
  assign off     = addr_q[3:2];
  assign tag     = addr_q[31 -: TagW];
  assign hit     = pend_q && valid_q[idx] && (tag_q[idx] == tag);
  assign capture = CPU_RD && !CPU_STALL;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    flush_seen_d = flush_seen_q | CPU_FLUSH;
    CPU_INSTR    = 32'h0;
    CPU_VALID    = 1'b0;
    CPU_STALL    = 1'b0;
    MEM_REQ      = 1'b0;
    MEM_ADDR     = 32'h0;
    lookup_hit   = 1'b0;
    miss_start   = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      StLookup: begin
        // A flush in the miss-detect cycle also keeps the refilled line invalid.
        flush_seen_d = CPU_FLUSH;
        if (pend_q) begin
          if (hit) begin
            CPU_VALID  = 1'b1;
            CPU_INSTR  = data_q[idx][off];
            lookup_hit = 1'b1;
          end else begin
            CPU_STALL  = 1'b1;
            word_d     = 2'd0;
            miss_start = 1'b1;
            state_d    = StRefill;
          end
        end
      end
      StRefill: begin
        CPU_STALL = 1'b1;
        MEM_REQ   = 1'b1;
        MEM_ADDR  = {addr_q[31:4], word_q, 2'b00};
        if (MEM_ACK) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) begin
            fill_done = 1'b1;
            state_d   = StFilled;
          end
        end
      end
      StFilled: begin
        CPU_VALID = 1'b1;
        CPU_INSTR = line_q[off];
        state_d   = StLookup;
      end
      default: state_d = StLookup;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (capture) begin
      pend_d = 1'b1;
    end else if (lookup_hit || (state_q == StFilled)) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StLookup;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      word_q       <= 2'd0;
      flush_seen_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      word_q       <= word_d;
      flush_seen_q <= flush_seen_d;
      if (capture) begin
        addr_q <= CPU_ADDR[31:2];
      end
      if (CPU_FLUSH) begin
        valid_q <= '0;
      end
      if (fill_done && !flush_seen_d) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Storage arrays need no reset: valid bits gate every read.
  always_ff @(posedge CLK) begin
    if ((state_q == StRefill) && MEM_ACK) begin
      line_q[word_q] <= MEM_RDATA;
    end
    if (fill_done) begin
      tag_q[idx]     <= tag;
      data_q[idx][0] <= line_q[0];
      data_q[idx][1] <= line_q[1];
      data_q[idx][2] <= line_q[2];
      data_q[idx][3] <= MEM_RDATA;
    end
  end

`ifdef OTTER_ICACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hits_q   <= 32'h0;
      misses_q <= 32'h0;
    end else begin
      if (lookup_hit) hits_q <= hits_q + 32'd1;
      if (miss_start) misses_q <= misses_q + 32'd1;
    end
  end

  assign STAT_HITS   = hits_q;
  assign STAT_MISSES = misses_q;
`endif

endmodule

// File: tb/tb_otter_icache.sv
// Directed bench for otter_icache: cold miss, hit streaming, eviction, slow memory, flush, reset.
module tb_otter_icache;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_flush;
  logic [31:0] cpu_instr;
  logic        cpu_valid;
  logic        cpu_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef OTTER_ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned ack_wait = 0;
  int unsigned ack_count = 0;
  logic [31:0] ack_log [$];

  otter_icache #(.LINES(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .CPU_ADDR   (cpu_addr),
    .CPU_RD     (cpu_rd),
    .CPU_FLUSH  (cpu_flush),
    .CPU_INSTR  (cpu_instr),
    .CPU_VALID  (cpu_valid),
    .CPU_STALL  (cpu_stall),
    .MEM_REQ    (mem_req),
    .MEM_ADDR   (mem_addr),
    .MEM_ACK    (mem_ack),
    .MEM_RDATA  (mem_rdata)
`ifdef OTTER_ICACHE_STATS_EN
    ,
    .STAT_HITS  (stat_hits),
    .STAT_MISSES(stat_misses)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hBEEF} ^ {16'h0, a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory: acks after ack_wait idle cycles per word, checks address hold while waiting.
  initial begin
    int unsigned wait_cnt;
    logic [31:0] held;
    wait_cnt  = 0;
    held      = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_DEAD;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (wait_cnt > 0) check_eq("mem_addr_hold", mem_addr, held);
        held = mem_addr;
        if (wait_cnt == ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          ack_log.push_back(mem_addr);
          ack_count++;
          wait_cnt  = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hDEAD_DEAD;
          wait_cnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_DEAD;
        wait_cnt  = 0;
      end
    end
  end

  task automatic fetch_expect(input string tag, input logic [31:0] addr,
                              input int unsigned exp_lat, input int unsigned exp_acks);
    int unsigned n, st, a0;
    @(negedge clk);
    cpu_addr = addr;
    cpu_rd   = 1'b1;
    a0       = ack_count;
    @(negedge clk);
    cpu_rd = 1'b0;
    n  = 1;
    st = 0;
    while (!cpu_valid && n < 200) begin
      if (cpu_stall) st++;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_instr"}, cpu_instr, mem_word({addr[31:2], 2'b00}));
    check_eq({tag, "_stall_cycles"}, st, exp_lat - 1);
    check_eq({tag, "_stall_at_valid"}, {31'h0, cpu_stall}, 32'h0);
    check_eq({tag, "_acks"}, ack_count - a0, exp_acks);
  endtask

  task automatic check_log(input string tag, input logic [31:0] base);
    check_eq({tag, "_log_len"}, ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check_eq({tag, "_log_addr"}, ack_log[i], base + 32'(4 * i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    rst       = 1'b1;
    cpu_addr  = 32'h0;
    cpu_rd    = 1'b0;
    cpu_flush = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_instr", cpu_instr, 32'h0);
    check_eq("rst_valid", {31'h0, cpu_valid}, 32'h0);
    check_eq("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check_eq("rst_req",   {31'h0, mem_req},   32'h0);
    check_eq("rst_maddr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_valid", {31'h0, cpu_valid}, 32'h0);

    // Cold miss with zero-wait memory.
    ack_log.delete();
    fetch_expect("cold", 32'h0000_0000, 6, 4);
    check_log("cold", 32'h0000_0000);

    // Back-to-back hits on the same line.
    @(negedge clk);
    cpu_addr = 32'h4;
    cpu_rd   = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_eq("stream_valid", {31'h0, cpu_valid}, 32'h1);
      check_eq("stream_instr", cpu_instr, mem_word(32'(4 * i)));
      check_eq("stream_req", {31'h0, mem_req}, 32'h0);
      cpu_addr = 32'(4 * (i + 1));
      if (i == 3) cpu_rd = 1'b0;
    end
    @(negedge clk);
    check_eq("stream_end_valid", {31'h0, cpu_valid}, 32'h0);

    // Conflict eviction in index 0; byte-lane bits ignored on 0x102.
    ack_log.delete();
    fetch_expect("evict", 32'h0000_0100, 6, 4);
    check_log("evict", 32'h0000_0100);
    fetch_expect("evict_hit", 32'h0000_0102, 1, 0);
    fetch_expect("refetch0", 32'h0000_0000, 6, 4);

    // Slow memory: 3 idle cycles before each ack.
    ack_wait = 3;
    ack_log.delete();
    fetch_expect("slow", 32'h0000_0048, 18, 4);
    check_log("slow", 32'h0000_0040);
    ack_wait = 0;
    fetch_expect("slow_hit", 32'h0000_004C, 1, 0);

    // Flush during refill: instruction delivered, line and others left invalid.
    @(negedge clk);
    cpu_addr = 32'h0000_0200;
    cpu_rd   = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    check_eq("flush_lookup_stall", {31'h0, cpu_stall}, 32'h1);
    @(negedge clk);
    cpu_flush = 1'b1;
    check_eq("flush_refill_req", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    cpu_flush = 1'b0;
    n = 3;
    while (!cpu_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("flush_latency", n, 6);
    check_eq("flush_instr", cpu_instr, mem_word(32'h0000_0200));
    fetch_expect("flush_other", 32'h0000_0040, 6, 4);
    fetch_expect("flush_same", 32'h0000_0200, 6, 4);

    // Flush coincident with a hit still returns the hit.
    @(negedge clk);
    cpu_addr = 32'h0000_0204;
    cpu_rd   = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    check_eq("cohit_valid", {31'h0, cpu_valid}, 32'h1);
    check_eq("cohit_instr", cpu_instr, mem_word(32'h0000_0204));
    cpu_flush = 1'b1;
    @(negedge clk);
    cpu_flush = 1'b0;
    check_eq("cohit_after_valid", {31'h0, cpu_valid}, 32'h0);
    fetch_expect("cohit_miss", 32'h0000_0208, 6, 4);

    // Reset after the second ack of a refill.
    @(negedge clk);
    cpu_addr = 32'h0000_0300;
    cpu_rd   = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_req", {31'h0, mem_req}, 32'h0);
    check_eq("midrst_stall", {31'h0, cpu_stall}, 32'h0);
    check_eq("midrst_maddr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_valid", {31'h0, cpu_valid}, 32'h0);
    check_eq("postrst_req", {31'h0, mem_req}, 32'h0);
    ack_log.delete();
    fetch_expect("postrst", 32'h0000_0300, 6, 4);
    check_log("postrst", 32'h0000_0300);
`ifdef OTTER_ICACHE_STATS_EN
    check_eq("stat_misses", stat_misses, 32'd1);
    check_eq("stat_hits", stat_hits, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
